// File: rtl/world.sv
// world: pipe-cleaning robot top with map, sensors, robot FSM, key handling and VGA scan lookup
module world #(
   parameter int START_ROW = 10,
   parameter int START_COL = 1
) (
   input  logic       clock_50,
   input  logic       reset_key,
   input  logic       mode_toggle,
   input  logic       clock_toggle,
   output logic       mode,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic [3:0] sprite,
   output logic [1:0] robot_cursor_flags,
   output logic [4:0] robot_type
);
   typedef enum logic [2:0] {
      S_FOLLOW = 3'b000, S_ROTATE = 3'b001, S_MOVED = 3'b010,
      S_STANDBY = 3'b011, S_FIRST = 3'b100, S_RESETING = 3'b101
   } state_t;
   typedef enum logic [2:0] {A_NONE, A_FRONT, A_RIGHT, A_LEFT, A_REMOVE} act_t;
   localparam logic [1:0] NORTH = 2'b00, SOUTH = 2'b01, EAST = 2'b10, WEST = 2'b11;
   logic [2:0] r_map [1:10][1:20];
   logic [2:0] r_mt, r_ct;
   logic       r_mode, r_rclk, r_tick;
   logic [3:0] r_row;
   logic [4:0] r_col;
   logic [1:0] r_ori, r_trs, r_flags;
   logic [9:0] r_x, r_y;
   logic [3:0] r_sprite;
   state_t     r_st, w_nst;
   act_t       w_act;
   logic [8:0] w_fp, w_lp;
   logic       w_fv, w_lv, w_head, w_left, w_barrier, w_under, w_chip, w_vis;
   logic [2:0] w_fcell, w_lcell;
   logic [3:0] w_vr;
   logic [4:0] w_vc;
   function automatic logic [2:0] def_cell(input int r, input int c);
      if (r == 6 && c >= 5 && c <= 15) return 3'd1;
      if (r == 2 && c >= 3 && c <= 8) return 3'd1;
      if (r == 6 && c == 16) return 3'd4;
      if (r == 10 && c == 12) return 3'd2;
      if (r == 10 && c == 1) return 3'd5;
      return 3'd0;
   endfunction
   function automatic logic [1:0] rot_r(input logic [1:0] o);
      return o == NORTH ? EAST : o == EAST ? SOUTH : o == SOUTH ? WEST : NORTH;
   endfunction
   function automatic logic [1:0] rot_l(input logic [1:0] o);
      return o == NORTH ? WEST : o == WEST ? SOUTH : o == SOUTH ? EAST : NORTH;
   endfunction
   function automatic logic [8:0] nb(input logic [1:0] o, input logic [3:0] r, input logic [4:0] c);
      return o == NORTH ? {r - 4'd1, c} : o == SOUTH ? {r + 4'd1, c} :
             o == EAST ? {r, c + 5'd1} : {r, c - 5'd1};
   endfunction
   function automatic logic on_map(input logic [8:0] p);
      return p[8:5] >= 4'd1 && p[8:5] <= 4'd10 && p[4:0] >= 5'd1 && p[4:0] <= 5'd20;
   endfunction
   assign w_fp      = nb(r_ori, r_row, r_col);
   assign w_lp      = nb(rot_l(r_ori), r_row, r_col);
   assign w_fv      = on_map(w_fp);
   assign w_lv      = on_map(w_lp);
   assign w_fcell   = w_fv ? r_map[w_fp[8:5]][w_fp[4:0]] : 3'd1;
   assign w_lcell   = w_lv ? r_map[w_lp[8:5]][w_lp[4:0]] : 3'd1;
   assign w_head    = w_fcell == 3'd1;
   assign w_left    = w_lcell == 3'd1;
   assign w_barrier = w_fcell >= 3'd2 && w_fcell <= 3'd4;
   assign w_under   = r_map[r_row][r_col] == 3'd5;
   assign w_chip    = r_trs == 2'b01 || r_trs == 2'b10;
   assign w_vis     = r_x < 10'd640 && r_y < 10'd480;
   assign w_vr      = 4'(r_y / 10'd48 + 10'd1);
   assign w_vc      = r_x[9:5] + 5'd1;
   assign mode               = r_mode;
   assign pixel_x            = r_x;
   assign pixel_y            = r_y;
   assign sprite             = r_sprite;
   assign robot_cursor_flags = r_flags;
   assign robot_type         = {r_st, r_ori};
   // synchronize both keys; toggle mode on a press and emit one robot step pulse per press in run mode
   always_ff @(posedge clock_50 or posedge reset_key)
      if (reset_key) begin
         r_mt   <= 3'b111;
         r_ct   <= 3'b111;
         r_mode <= 1'b0;
         r_rclk <= 1'b0;
      end else begin
         r_mt   <= {r_mt[1:0], mode_toggle};
         r_ct   <= {r_ct[1:0], clock_toggle};
         r_mode <= r_mode ^ (r_mt[2] & ~r_mt[1]);
         r_rclk <= r_mode & r_ct[2] & ~r_ct[1];
      end
   // robot act_state register, advanced only on robot steps
   always_ff @(posedge clock_50 or posedge reset_key)
      if (reset_key) r_st <= S_RESETING;
      else if (r_rclk) r_st <= w_nst;
   // choose the next act_state and the action from the sensors (left-hand wall follower)
   always_comb begin
      w_nst = r_st;
      w_act = A_NONE;
      case (r_st)
         S_RESETING: w_nst = S_FIRST;
         S_FIRST:
            if (w_barrier) begin
               w_act = A_REMOVE;
               w_nst = S_MOVED;
            end else if (!w_head) w_act = A_FRONT;
            else begin
               w_act = A_RIGHT;
               w_nst = S_FOLLOW;
            end
         S_FOLLOW, S_MOVED:
            if (w_under) w_nst = S_STANDBY;
            else if (w_barrier) begin
               w_act = A_REMOVE;
               w_nst = S_MOVED;
            end else if (!w_left) begin
               w_act = A_LEFT;
               w_nst = S_ROTATE;
            end else if (!w_head) begin
               w_act = A_FRONT;
               w_nst = S_MOVED;
            end else begin
               w_act = A_RIGHT;
               w_nst = S_ROTATE;
            end
         S_ROTATE:
            if (w_barrier) begin
               w_act = A_REMOVE;
               w_nst = S_MOVED;
            end else if (!w_head) begin
               w_act = A_FRONT;
               w_nst = S_MOVED;
            end else w_act = A_RIGHT;
         default: ;
      endcase
   end
   // apply the action to position, heading and trash-removal progress on each robot step
   always_ff @(posedge clock_50 or posedge reset_key)
      if (reset_key) begin
         r_row <= 4'(START_ROW);
         r_col <= 5'(START_COL);
         r_ori <= NORTH;
         r_trs <= 2'b00;
      end else if (r_rclk) begin
         if (w_act == A_FRONT) begin
            r_row <= w_fp[8:5];
            r_col <= w_fp[4:0];
         end
         r_ori <= w_act == A_RIGHT ? rot_r(r_ori) : w_act == A_LEFT ? rot_l(r_ori) : r_ori;
         r_trs <= w_act != A_REMOVE ? 2'b00 : w_chip ? (w_fcell == 3'd2 ? 2'b11 : 2'b10) : 2'b01;
      end
   // map cells: defaults on reset, trash in front lowered one level per chipping step
   always_ff @(posedge clock_50 or posedge reset_key)
      if (reset_key) begin
         for (int r = 1; r <= 10; r++)
            for (int c = 1; c <= 20; c++)
               r_map[4'(r)][5'(c)] <= def_cell(r, c);
      end else if (r_rclk && w_act == A_REMOVE && w_chip)
         r_map[w_fp[8:5]][w_fp[4:0]] <= w_fcell == 3'd2 ? 3'd0 : w_fcell - 3'd1;
   // scan 800x525 at half clock rate and register the cell lookup for the pixel being left
   always_ff @(posedge clock_50 or posedge reset_key)
      if (reset_key) begin
         r_tick   <= 1'b0;
         r_x      <= 10'd0;
         r_y      <= 10'd0;
         r_sprite <= 4'd0;
         r_flags  <= 2'b00;
      end else begin
         r_tick <= ~r_tick;
         if (r_tick) begin
            r_x      <= r_x == 10'd799 ? 10'd0 : r_x + 10'd1;
            r_y      <= r_x == 10'd799 ? (r_y == 10'd524 ? 10'd0 : r_y + 10'd1) : r_y;
            r_sprite <= w_vis ? {1'b0, r_map[w_vr][w_vc]} : 4'd0;
            r_flags  <= {w_vis && w_fv && w_vr == w_fp[8:5] && w_vc == w_fp[4:0],
                         w_vis && w_vr == r_row && w_vc == r_col};
         end
      end
endmodule

// File: tb/tb_world.sv
// tb_world: directed bench for the robot world top
module tb_world;
   logic clk = 1'b0, rst = 1'b1, mode_toggle = 1'b1, clock_toggle = 1'b1;
   logic       mode, mode2;
   logic [9:0] px, py, px2, py2;
   logic [3:0] spr, spr2;
   logic [1:0] flg, flg2;
   logic [4:0] rt, rt2;
   int total = 0, bad = 0, rclk_cnt = 0, viol = 0;
   logic [1:0] e_trs  [0:5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
   logic [2:0] e_cell [0:5] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0};
   always #5 clk = ~clk;
   world dut (
      .clock_50(clk), .reset_key(rst), .mode_toggle(mode_toggle), .clock_toggle(clock_toggle),
      .mode(mode), .pixel_x(px), .pixel_y(py), .sprite(spr),
      .robot_cursor_flags(flg), .robot_type(rt)
   );
   world #(.START_ROW(7), .START_COL(16)) dut2 (
      .clock_50(clk), .reset_key(rst), .mode_toggle(mode_toggle), .clock_toggle(clock_toggle),
      .mode(mode2), .pixel_x(px2), .pixel_y(py2), .sprite(spr2),
      .robot_cursor_flags(flg2), .robot_type(rt2)
   );
   always @(posedge clk) if (dut.r_rclk) rclk_cnt <= rclk_cnt + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      clock_toggle = 1'b0;
      repeat (4) @(posedge clk);
      #1 clock_toggle = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask
   task automatic wait_pix(input int x, input int y);
      int n = 0;
      while ((px != 10'(x) || py != 10'(y)) && n < 90000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("wait_pix", 32'(n < 90000), 1);
   endtask
   initial begin
      logic h;
      logic [3:0] r;
      logic [4:0] c;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_px", px, 0);
      chk("rst_py", py, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mode", mode, 0);
      chk("rst_type", rt, 5'b10100);
      chk("rst_row", dut.r_row, 10);
      chk("rst_col", dut.r_col, 1);
      chk("rst_row2", dut2.r_row, 7);
      chk("rst_col2", dut2.r_col, 16);
      step();
      step();
      chk("idle_rclk", rclk_cnt, 0);
      chk("idle_type", rt, 5'b10100);
      mode_toggle = 1'b0;
      repeat (4) @(posedge clk);
      #1 mode_toggle = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("run_mode", mode, 1);
      step();
      chk("first_rclk", rclk_cnt, 1);
      chk("first_type", rt, 5'b10000);
      chk("trs2_s1", dut2.r_trs, e_trs[0]);
      chk("lvl2_s1", dut2.r_map[6][16], e_cell[0]);
      for (int i = 1; i <= 9; i++) begin
         step();
         chk("north_row", dut.r_row, 10 - i);
         if (i <= 5) begin
            chk("trs2", dut2.r_trs, e_trs[i]);
            chk("lvl2", dut2.r_map[6][16], e_cell[i]);
         end
         if (i == 5) begin
            chk("type2_cleared", rt2, 5'b00111);
            chk("barrier2_cleared", dut2.w_barrier, 0);
         end
      end
      chk("steps_rclk", rclk_cnt, 10);
      chk("top_type", rt, 5'b10000);
      step();
      chk("turn_type", rt, 5'b00010);
      chk("turn_row", dut.r_row, 1);
      chk("turn_col", dut.r_col, 1);
      wait_pix(40, 1);
      chk("front_flags", flg, 2'b10);
      chk("front_sprite", spr, 0);
      wait_pix(10, 2);
      chk("robot_flags", flg, 2'b01);
      wait_pix(700, 2);
      chk("offscreen_flags", flg, 2'b00);
      for (int i = 0; i < 100; i++) begin
         h = dut.w_head;
         r = dut.r_row;
         c = dut.r_col;
         step();
         if (dut.r_row < 1 || dut.r_row > 10 || dut.r_col < 1 || dut.r_col > 20) viol++;
         if (h && (dut.r_row != r || dut.r_col != c)) viol++;
      end
      chk("walk_viol", viol, 0);
      chk("home_type", rt, 5'b01111);
      chk("home_row", dut.r_row, 10);
      chk("home_col", dut.r_col, 1);
      chk("trash_gone", dut.r_map[10][12], 0);
      wait_pix(40, 48);
      chk("free_sprite", spr, 0);
      wait_pix(70, 48);
      chk("wall_sprite", spr, 1);
      chk("wall_flags", flg, 2'b00);
      clock_toggle = 1'b0;
      rst = 1'b1;
      #2;
      chk("mid_mode", mode, 0);
      chk("mid_type", rt, 5'b10100);
      chk("mid_row", dut.r_row, 10);
      chk("mid_col", dut.r_col, 1);
      chk("mid_px", px, 0);
      chk("mid_map", dut.r_map[10][12], 2);
      rst = 1'b0;
      clock_toggle = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
